// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler for the 16-in/128-out async FIFO on the PCIe path (read clock domain).
// Define FIFO_BURST_RD_TIMEOUT_FLUSH_EN to flush sub-threshold residue as single-word bursts after TIMEOUT idle cycles.
//   state | meaning
//   IDLE  | waiting for a full burst (or flush timeout) with enable=1
//   REQ   | burst_req held with burst_len until burst_gnt
//   XFER  | draining burst_len words through the skid buffer
module fifo_burst_rd_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic                  burst_req,
  output logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  burst_gnt,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  burst_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic [LEN_WIDTH-1:0]  r_sent;
  logic                  r_req;
  logic                  r_inflight;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_skid [2];
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic       w_pop;
  logic       w_rd;
  logic       w_last;
  logic       w_start;
  logic       w_flush;
  logic [1:0] w_used;

  // A word leaving the skid this cycle frees its slot, which keeps one word per cycle under m_ready=1.
  assign w_pop   = (r_occ != 2'd0) && m_ready;
  assign w_used  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_rd    = !rd_rst && (r_state == XFER) && !fifo_rd_empty &&
                   (r_rd_cnt < r_len) && (w_used < 2'd2);
  assign w_last  = w_pop && m_last;
  assign w_start = (r_state == IDLE) && enable && !fifo_almost_empty;

`ifdef FIFO_BURST_RD_TIMEOUT_FLUSH_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] r_tmo;

  assign w_flush = (r_state == IDLE) && enable && !fifo_rd_empty && fifo_almost_empty &&
                   (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge rd_clk) begin
    if (rd_rst || fifo_rd_empty || !fifo_almost_empty || (r_state != IDLE)) begin
      r_tmo <= '0;
    end else if (enable) begin
      r_tmo <= w_flush ? '0 : r_tmo + TMO_W'(1);
    end
  end
`else
  assign w_flush = 1'b0;
`endif

  assign fifo_rd_en = w_rd;
  assign burst_req  = r_req;
  assign burst_len  = r_len;
  assign m_data     = r_skid[r_rptr];
  assign m_valid    = (r_occ != 2'd0);
  assign m_last     = m_valid && (r_sent == r_len - LEN_WIDTH'(1));
  assign busy       = (r_state != IDLE);
  assign burst_cnt  = r_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= w_rd;
      if (r_inflight) begin
        r_skid[r_wptr] <= fifo_rd_data;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

      case (r_state)
        IDLE: begin
          if (w_start || w_flush) begin
            r_len    <= w_start ? LEN_WIDTH'(BURST_LEN) : LEN_WIDTH'(1);
            r_req    <= 1'b1;
            r_rd_cnt <= '0;
            r_sent   <= '0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (burst_gnt) begin
            r_req   <= 1'b0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_rd)  r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
          if (w_pop) r_sent   <= r_sent + LEN_WIDTH'(1);
          if (w_last) begin
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: behavioural 1-cycle-latency FIFO plus handshake-driven burst checks.
module tb_fifo_burst_rd_ctrl;

  logic         rd_clk = 1'b0;
  logic         rd_rst;
  logic         enable;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data = '0;
  logic         fifo_rd_empty = 1'b1;
  logic         fifo_almost_empty = 1'b1;
  logic         burst_req;
  logic [7:0]   burst_len;
  logic         burst_gnt;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic [15:0]  burst_cnt;

  int n_chk = 0;
  int n_err = 0;
  int push_idx = 1;
  int exp_idx_g = 1;
  int pop_cnt = 0;
  int exp_cnt = 0;
  int lat;
  int req_seen;
  int beats;
  logic [127:0] q[$];

  always #5 rd_clk = ~rd_clk;

  fifo_burst_rd_ctrl #(
    .DATA_WIDTH(128), .BURST_LEN(8), .LEN_WIDTH(8), .TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
    .burst_req(burst_req), .burst_len(burst_len), .burst_gnt(burst_gnt),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  // FIFO model: data one cycle after rd_en, flags reflect contents after each edge.
  always @(posedge rd_clk) begin : fifo_model
    logic [127:0] tmp;
    if (fifo_rd_en && q.size() > 0) begin
      tmp = q.pop_front();
      fifo_rd_data <= tmp;
      pop_cnt      <= pop_cnt + 1;
    end
    fifo_rd_empty     <= (q.size() == 0);
    fifo_almost_empty <= (q.size() < 8);
  end

  function automatic logic [127:0] word(input int i);
    return {4{32'hA000_0000 + 32'(i)}};
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(word(push_idx));
      push_idx++;
    end
  endtask

  task automatic check_rst(input string tag);
    check_val({tag, "_rd_en"},  128'(fifo_rd_en), 128'(0));
    check_val({tag, "_req"},    128'(burst_req),  128'(0));
    check_val({tag, "_len"},    128'(burst_len),  128'(0));
    check_val({tag, "_valid"},  128'(m_valid),    128'(0));
    check_val({tag, "_last"},   128'(m_last),     128'(0));
    check_val({tag, "_data"},   m_data,           128'(0));
    check_val({tag, "_busy"},   128'(busy),       128'(0));
    check_val({tag, "_cnt"},    128'(burst_cnt),  128'(0));
  endtask

  // Grants each request gnt_dly cycles after it appears, checks every beat in order,
  // and returns cycles from XFER entry to the first burst's last handshake.
  task automatic run_bursts(input int n_bursts, input int exp_len, input int ready_mode,
                            input int gnt_dly, input int budget, output int first_lat);
    int bursts, beat_in, age, gnt_k;
    logic [127:0] prev_d;
    logic prev_l, prev_stall;
    bursts = 0; beat_in = 0; age = 0; gnt_k = -1; first_lat = -1;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int k = 0; k < budget && bursts < n_bursts; k++) begin
      @(negedge rd_clk);
      burst_gnt = 1'b0;
      if (burst_req) begin
        if (age == gnt_dly) begin
          burst_gnt = 1'b1;
          if (gnt_k < 0) gnt_k = k;
          check_val("req_len", 128'(burst_len), 128'(exp_len));
        end
        age++;
      end else begin
        age = 0;
      end
      m_ready = (ready_mode == 0) ? 1'b1 : ((k % 2) == 0);
      if (prev_stall) begin
        check_val("stall_data", m_data, prev_d);
        check_val("stall_last", 128'(m_last), 128'(prev_l));
      end
      if (m_valid && m_ready) begin
        check_val("beat_data", m_data, word(exp_idx_g));
        exp_idx_g++;
        check_val("beat_last", 128'(m_last), 128'(beat_in == exp_len - 1));
        if (beat_in == exp_len - 1) begin
          beat_in = 0;
          bursts++;
          if (bursts == 1) first_lat = k - gnt_k - 1;
        end else begin
          beat_in++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
    burst_gnt = 1'b0;
    m_ready = 1'b1;
    check_val("bursts_done", 128'(bursts), 128'(n_bursts));
  endtask

  task automatic count_req(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge rd_clk);
      if (burst_req) seen++;
    end
  endtask

  task automatic wait_req(input int budget);
    for (int k = 0; k < budget && !burst_req; k++) @(negedge rd_clk);
    check_val("req_seen", 128'(burst_req), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst = 1'b1; enable = 1'b0; m_ready = 1'b0; burst_gnt = 1'b0;
    repeat (3) @(negedge rd_clk);
    check_rst("reset");
    rd_rst = 1'b0;

    // Grant while idle must be ignored
    burst_gnt = 1'b1;
    @(negedge rd_clk);
    burst_gnt = 1'b0;
    @(negedge rd_clk);
    check_val("idle_gnt_busy", 128'(busy), 128'(0));
    check_val("idle_gnt_req", 128'(burst_req), 128'(0));

    // Single burst, grant two cycles after request, m_ready=1
    push(8);
    enable = 1'b1;
    run_bursts(1, 8, 0, 2, 60, lat);
    exp_cnt = 1;
    check_val("a_latency", 128'(lat), 128'(9));
    @(negedge rd_clk);
    check_val("a_busy_after", 128'(busy), 128'(0));
    check_val("a_cnt", 128'(burst_cnt), 128'(exp_cnt));
    check_val("a_no_req", 128'(burst_req), 128'(0));

    // m_ready toggling every cycle
    push(8);
    run_bursts(1, 8, 1, 0, 80, lat);
    exp_cnt = 2;
    @(negedge rd_clk);
    check_val("b_cnt", 128'(burst_cnt), 128'(exp_cnt));

    // Two back-to-back bursts from 16 words
    push(16);
    run_bursts(2, 8, 0, 0, 80, lat);
    exp_cnt = 4;
    check_val("c_latency", 128'(lat), 128'(9));
    @(negedge rd_clk);
    check_val("c_cnt", 128'(burst_cnt), 128'(exp_cnt));
    check_val("c_fifo_empty", 128'(fifo_rd_empty), 128'(1));
    check_val("c_q_size", 128'(q.size()), 128'(0));

    // Three residual words below the threshold
    push(3);
`ifdef FIFO_BURST_RD_TIMEOUT_FLUSH_EN
    run_bursts(3, 1, 0, 0, 120, lat);
    exp_cnt = 7;
    @(negedge rd_clk);
    check_val("flush_cnt", 128'(burst_cnt), 128'(exp_cnt));
    check_val("flush_len", 128'(burst_len), 128'(1));
`else
    count_req(60, req_seen);
    check_val("no_flush_req", 128'(req_seen), 128'(0));
    check_val("no_flush_cnt", 128'(burst_cnt), 128'(exp_cnt));
`endif

    // enable dropped during REQ: burst still completes, no new one starts
    push(8);
    wait_req(10);
    enable = 1'b0;
    run_bursts(1, 8, 0, 2, 60, lat);
    exp_cnt++;
    @(negedge rd_clk);
    check_val("e_cnt", 128'(burst_cnt), 128'(exp_cnt));
    push(8);
    count_req(30, req_seen);
    check_val("e_no_req", 128'(req_seen), 128'(0));
    check_val("e_busy", 128'(busy), 128'(0));

    // Reset at beat 4 of a burst
    enable = 1'b1;
    wait_req(10);
    burst_gnt = 1'b1;
    m_ready = 1'b1;
    beats = 0;
    for (int k = 0; k < 30 && beats < 4; k++) begin
      @(negedge rd_clk);
      burst_gnt = 1'b0;
      if (m_valid) begin
        check_val("d_beat_data", m_data, word(exp_idx_g));
        exp_idx_g++;
        beats++;
      end
    end
    check_val("d_beats_before_rst", 128'(beats), 128'(4));
    rd_rst = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    check_rst("d_reset");
    exp_cnt = 0;
    exp_idx_g = pop_cnt + 1;
    count_req(10, req_seen);
    check_val("d_no_req_below_thr", 128'(req_seen), 128'(0));
    push(8);
    run_bursts(1, 8, 0, 1, 60, lat);
    exp_cnt = 1;
    @(negedge rd_clk);
    check_val("d_cnt", 128'(burst_cnt), 128'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
